// File: rtl/alu_pkg.sv
// Shared opcode and shifter-mode encodings for the alu block.
// No handshake: a new operation is accepted on every rising clk edge.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_NAND = 4'd6,
    OP_NOR  = 4'd7,
    OP_XNOR = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_SRA  = 4'd11,
    OP_ROL  = 4'd12,
    OP_ROR  = 4'd13,
    OP_INC  = 4'd14,
    OP_DEC  = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    SH_SHL = 3'd0,
    SH_SHR = 3'd1,
    SH_SRA = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } sh_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit; shift_out is the last bit shifted out
// (shifts) or the bit rotated into the vacated end (rotates), 0 when sh==0.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   sh,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] res,
  output logic             shift_out
);

  sh_mode_e          mode_e;
  logic [WIDTH:0]    shl_ext;
  logic [WIDTH:0]    shr_ext;
  logic [WIDTH:0]    sra_ext;
  logic [SHW-1:0]    ror_amt;
  logic [WIDTH-1:0]  rot_res;
  logic              sh_nz;

  assign mode_e = sh_mode_e'(mode);
  assign sh_nz  = (sh != '0);

  // An extra guard bit on the far side catches the bit shifted out.
  assign shl_ext = {1'b0, a} << sh;
  assign shr_ext = {a, 1'b0} >> sh;
  assign sra_ext = $signed({a, 1'b0}) >>> sh;

  // Rotate left by sh is rotate right by (WIDTH - sh) mod WIDTH.
  assign ror_amt = (mode_e == SH_ROL) ? (~sh + 1'b1) : sh;
  assign rot_res = WIDTH'({a, a} >> ror_amt);

  always_comb begin
    res       = a;
    shift_out = 1'b0;
    case (mode_e)
      SH_SHL: begin
        res       = shl_ext[WIDTH-1:0];
        shift_out = shl_ext[WIDTH];
      end
      SH_SHR: begin
        res       = shr_ext[WIDTH:1];
        shift_out = shr_ext[0];
      end
      SH_SRA: begin
        res       = sra_ext[WIDTH:1];
        shift_out = sra_ext[0];
      end
      SH_ROL: begin
        res       = rot_res;
        shift_out = sh_nz & rot_res[0];
      end
      SH_ROR: begin
        res       = rot_res;
        shift_out = sh_nz & rot_res[WIDTH-1];
      end
      default: begin
        res       = a;
        shift_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// 16-operation integer ALU with registered result and carry/overflow/zero/negative flags.
// One-cycle latency, no enable, no handshake: inputs are captured on every rising edge.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluop,
  output logic [WIDTH-1:0] o,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SHW = $clog2(WIDTH);

  alu_op_e          op;
  logic [WIDTH-1:0] addend;
  logic             is_sub;
  logic [WIDTH:0]   arith;
  logic             arith_ov;
  logic [2:0]       sh_mode;
  logic [WIDTH-1:0] sh_res;
  logic             sh_out;

  logic [WIDTH-1:0] o_d, o_q;
  logic             carry_d, carry_q;
  logic             overflow_d, overflow_q;
  logic             zero_d, zero_q;
  logic             negative_d, negative_q;

  assign op = alu_op_e'(aluop);

  // One shared adder/subtractor serves ADD, SUB, INC and DEC; bit WIDTH is carry or borrow.
  assign addend = (op == OP_INC || op == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign is_sub = (op == OP_SUB || op == OP_DEC);
  assign arith  = is_sub ? ({1'b0, a} - {1'b0, addend}) : ({1'b0, a} + {1'b0, addend});

  always_comb begin
    if (is_sub) begin
      arith_ov = (a[WIDTH-1] != addend[WIDTH-1]) && (arith[WIDTH-1] != a[WIDTH-1]);
    end else begin
      arith_ov = (a[WIDTH-1] == addend[WIDTH-1]) && (arith[WIDTH-1] != a[WIDTH-1]);
    end
  end

  always_comb begin
    sh_mode = SH_SHL;
    case (op)
      OP_SHR:  sh_mode = SH_SHR;
      OP_SRA:  sh_mode = SH_SRA;
      OP_ROL:  sh_mode = SH_ROL;
      OP_ROR:  sh_mode = SH_ROR;
      default: sh_mode = SH_SHL;
    endcase
  end

  alu_shifter #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_shifter (
    .a        (a),
    .sh       (b[SHW-1:0]),
    .mode     (sh_mode),
    .res      (sh_res),
    .shift_out(sh_out)
  );

  always_comb begin
    o_d        = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        o_d        = arith[WIDTH-1:0];
        carry_d    = arith[WIDTH];
        overflow_d = arith_ov;
      end
      OP_AND:  o_d = a & b;
      OP_OR:   o_d = a | b;
      OP_XOR:  o_d = a ^ b;
      OP_NOT:  o_d = ~a;
      OP_NAND: o_d = ~(a & b);
      OP_NOR:  o_d = ~(a | b);
      OP_XNOR: o_d = ~(a ^ b);
      OP_SHL, OP_SHR, OP_SRA, OP_ROL, OP_ROR: begin
        o_d     = sh_res;
        carry_d = sh_out;
      end
      default: o_d = '0;
    endcase
    zero_d     = (o_d == '0);
    negative_d = o_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q        <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      o_q        <= o_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

  assign o        = o_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (WIDTH=8): directed scenarios plus a randomized
// stream compared against an integer-arithmetic reference model.
module tb_alu;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   aluop;
  logic [W-1:0] o;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         negative;

  int tests_run;
  int tests_failed;

  // Expected outputs packed as {o, carry, overflow, zero, negative}.
  logic [W+3:0] exp_q[$];

  alu #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .aluop   (aluop),
    .o       (o),
    .carry   (carry),
    .overflow(overflow),
    .zero    (zero),
    .negative(negative)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W+3:0] model(input int op, input int av, input int bv);
    int r, c, v, sh, sa, sb, s;
    c  = 0;
    v  = 0;
    sh = bv % W;
    sa = (av >= 128) ? av - 256 : av;
    sb = (bv >= 128) ? bv - 256 : bv;
    case (op)
      0: begin
        r = av + bv; c = (r > 255); s = sa + sb; v = (s > 127 || s < -128);
      end
      1: begin
        r = av - bv; c = (av < bv); s = sa - sb; v = (s > 127 || s < -128);
      end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: r = ~av;
      6: r = ~(av & bv);
      7: r = ~(av | bv);
      8: r = ~(av ^ bv);
      9: begin
        r = av << sh; c = (sh != 0) ? (av >> (W - sh)) & 1 : 0;
      end
      10: begin
        r = av >> sh; c = (sh != 0) ? (av >> (sh - 1)) & 1 : 0;
      end
      11: begin
        r = sa >>> sh; c = (sh != 0) ? (av >> (sh - 1)) & 1 : 0;
      end
      12: begin
        r = ((av << sh) | (av >> (W - sh))) & 255; c = (sh != 0) ? r & 1 : 0;
      end
      13: begin
        r = ((av >> sh) | (av << (W - sh))) & 255; c = (sh != 0) ? (r >> 7) & 1 : 0;
      end
      14: begin
        r = av + 1; c = (av == 255); v = (av == 127);
      end
      default: begin
        r = av - 1; c = (av == 0); v = (av == 128);
      end
    endcase
    r = r & 255;
    return {r[W-1:0], c[0], v[0], (r == 0), (r >= 128)};
  endfunction

  // ---------------- driver ----------------
  // Drives one operation, then samples 1 time unit after the capturing edge.
  task automatic drive(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    aluop = op;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W+3:0] observed();
    return {o, carry, overflow, zero, negative};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      tests_run++;
      if (observed() !== '0) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: got %h exp %h", i, observed(), 12'h000);
      end
    end
    rst_n = 1'b1;
    drive(4'd0, 8'd64, 8'd2);
    tests_run++;
    if (o !== 8'd66 || carry !== 1'b0 || zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got o=%0d c=%b z=%b exp o=66 c=0 z=0", o, carry, zero);
    end
  endtask

  task automatic test_sweep();
    int exp_o[16] = '{66, 62, 0, 66, 66, 191, 255, 189, 189, 0, 16, 16, 1, 16, 65, 63};
    for (int k = 0; k < 16; k++) begin
      drive(4'(k), 8'd64, 8'd2);
      tests_run++;
      if (o !== 8'(exp_o[k])) begin
        tests_failed++;
        $display("FAIL sweep_op%0d: got o=%0d exp o=%0d", k, o, exp_o[k]);
      end
      if (k == 9) begin
        tests_run++;
        if (carry !== 1'b1) begin
          tests_failed++;
          $display("FAIL sweep_shl_carry: got %b exp 1", carry);
        end
      end
      if (k == 2) begin
        tests_run++;
        if (zero !== 1'b1) begin
          tests_failed++;
          $display("FAIL sweep_and_zero: got %b exp 1", zero);
        end
      end
    end
  endtask

  task automatic test_arith_edges();
    logic [3:0]   ops[4]  = '{4'd0, 4'd0, 4'd1, 4'd15};
    logic [W-1:0] as[4]   = '{8'd255, 8'd127, 8'd0, 8'd128};
    logic [W-1:0] bs[4]   = '{8'd1, 8'd1, 8'd1, 8'd0};
    // {o, carry, overflow, zero, negative}
    logic [W+3:0] exps[4] = '{{8'd0, 4'b1010}, {8'd128, 4'b0101},
                              {8'd255, 4'b1001}, {8'd127, 4'b0100}};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], as[i], bs[i]);
      tests_run++;
      if (observed() !== exps[i]) begin
        tests_failed++;
        $display("FAIL arith_edge[%0d]: got %h exp %h", i, observed(), exps[i]);
      end
    end
  endtask

  task automatic test_shifts();
    logic [3:0]   ops[5]  = '{4'd11, 4'd10, 4'd9, 4'd13, 4'd12};
    logic [W-1:0] as[5]   = '{8'h80, 8'h81, 8'h01, 8'h01, 8'h81};
    logic [W-1:0] bs[5]   = '{8'd3, 8'd1, 8'h0A, 8'd1, 8'h08};
    logic [W+3:0] exps[5] = '{{8'hF0, 4'b0001}, {8'h40, 4'b1000},
                              {8'h04, 4'b0000}, {8'h80, 4'b1001},
                              {8'h81, 4'b0001}};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], as[i], bs[i]);
      tests_run++;
      if (observed() !== exps[i]) begin
        tests_failed++;
        $display("FAIL shift[%0d]: got %h exp %h", i, observed(), exps[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W+3:0] e;
    drive(4'd0, 8'd10, 8'd20);
    drive(4'd1, 8'd0, 8'd1);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (observed() !== '0) begin
      tests_failed++;
      $display("FAIL async_reset_immediate: got %h exp %h", observed(), 12'h000);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (observed() !== '0) begin
      tests_failed++;
      $display("FAIL async_reset_hold: got %h exp %h", observed(), 12'h000);
    end
    rst_n = 1'b1;
    e = model(15, 0, 0);
    drive(4'd15, 8'd0, 8'd0);
    tests_run++;
    if (observed() !== e) begin
      tests_failed++;
      $display("FAIL async_reset_resume: got %h exp %h", observed(), e);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] corner[6] = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'h01, 8'hFE};
    logic [3:0]   op;
    logic [W-1:0] av, bv;
    logic [W+3:0] e;
    int           errs;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      op = 4'($urandom_range(0, 15));
      av = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 8'($urandom);
      bv = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 8'($urandom);
      exp_q.push_back(model(int'(op), int'(av), int'(bv)));
      drive(op, av, bv);
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got %h exp %h", i, op, av, bv, observed(), e);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    a            = '0;
    b            = '0;
    aluop        = '0;
    #2;
    test_reset();
    test_sweep();
    test_arith_edges();
    test_shifts();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 16-operation integer ALU with a registered result and status flags.
- Operands a and b and a 4-bit opcode aluop are sampled every clock; the result and flags appear on the registered outputs one cycle later.
- Datapath primitive for small processor or datapath blocks; no handshake, so it accepts a new operation every cycle.

Parameters:
- WIDTH, 8, operand/result width in bits (must be a power of two, >= 4).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A (unsigned; signed view for overflow/SRA).
- b  input  WIDTH  operand B; shifts/rotates use b[log2(WIDTH)-1:0] as amount.
- aluop  input  4  operation select.
- o  output  WIDTH  registered result.
- carry  output  1  registered carry/borrow/shift-out flag.
- overflow  output  1  registered signed overflow flag.
- zero  output  1  registered, 1 when o == 0.
- negative  output  1  registered, equals o[WIDTH-1].

Behaviour:
- Reset: rst_n low asynchronously forces o=0, carry=0, overflow=0, zero=0, negative=0, held until rst_n deasserts. The first capture is on the first rising clk edge with rst_n high.
- Latency: the result for inputs present before rising edge N is visible on the outputs after edge N. The outputs update every cycle and there is no enable.
- Opcodes (result truncated to WIDTH bits):
  - 0 ADD a+b; carry = bit WIDTH of the sum.
  - 1 SUB a-b; carry = borrow (1 when a<b unsigned).
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT ~a.
  - 6 NAND.
  - 7 NOR.
  - 8 XNOR.
  - 9 SHL: a << sh, zero fill.
  - 10 SHR: a >> sh, logical.
  - 11 SRA: a >>> sh, sign fill from a[WIDTH-1].
  - 12 ROL: a rotated left by sh.
  - 13 ROR: a rotated right by sh.
  - 14 INC a+1; carry on wrap.
  - 15 DEC a-1; carry = borrow when a==0.
- sh = b[log2(WIDTH)-1:0]. Upper bits of b are ignored for opcodes 9-13, so a shift by WIDTH or more is impossible.
- carry for shifts (9-11): the last bit shifted out; 0 when sh==0. carry for rotates (12-13): the bit rotated into the vacated end (ROL: o[0], ROR: o[WIDTH-1]); 0 when sh==0. carry is 0 for opcodes 2-8.
- overflow: two's-complement overflow for ADD, SUB, INC (a==0111..1) and DEC (a==1000..0); 0 for all other opcodes.
- zero and negative are derived from the result being registered, for every opcode.
- Wrap-around: ADD/INC from all-ones wraps to 0 with carry=1; SUB/DEC below 0 wraps to all-ones with carry=1.
- Reset asserted mid-stream clears the outputs immediately. No operation is remembered across reset.
- Combinational path from inputs to the output registers only; no combinational input-to-output path.

Decomposition:
- Package alu_pkg holds the 4-bit opcode enum, with constants for ops 0-15 named as above (OP_ADD ... OP_DEC).
- Sub-module alu_shifter (combinational): inputs a, sh, and a 3-bit mode {SHL, SHR, SRA, ROL, ROR}; outputs the result and shift-out bit.
- The top level holds the adder/subtractor, logic ops, opcode mux, flag logic and output registers.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> o=0 and all flags 0. Then release with a=64, b=2, aluop=0 -> after next edge o=66, carry=0, zero=0.
- Sweep aluop 0..15 with a=64, b=2 at one op per cycle -> o sequence 66, 62, 0, 66, 66, 191, 255, 189, 189, 0, 16, 16, 1, 16, 65, 63, each one cycle after its op. Also check SHL carry=1 and AND zero=1.
- Arithmetic edges:
  - ADD 255+1 -> o=0, carry=1, zero=1.
  - ADD 127+1 -> o=128, overflow=1, negative=1.
  - SUB 0-1 -> o=255, carry=1.
  - DEC a=128 -> o=127, overflow=1.
- Shifts:
  - SRA a=0x80 b=3 -> o=0xF0, carry=0.
  - SHR a=0x81 b=1 -> o=0x40, carry=1.
  - b=0x0A used as a shift amount -> treated as sh=2.
  - ROR a=0x01 b=1 -> o=0x80, carry=1.
- Async reset mid-stream: assert rst_n low between clock edges while ops are streaming -> outputs go to 0 immediately without a clock edge. Deassert -> the pipeline resumes correctly on the next edge.
- Back-to-back random ops (1000 cycles) vs reference model -> o and all flags match with exactly 1-cycle latency.
